instr_seq: RTL and testbench

// - Multi-cycle fetch/decode/execute sequencer for the 8-bit core.
// - Fetches one instruction byte per instruction over a req/ack memory handshake and holds it in the instruction register.
// - Strobes the ALU and the register-file write enable in a fixed order.
// - Owns the program counter. Its instr output drives ctrl's instr input.

---
 rtl/instr_seq_if.sv | 12 +
 rtl/instr_seq.sv | 101 ++++++++++
 tb/tb_instr_seq.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/instr_seq_if.sv
// Fetch bus between the sequencer (master) and instruction memory (slave).
interface instr_seq_if #(
  parameter int PC_WIDTH = 16
);
  logic [PC_WIDTH-1:0] mem_addr;
  logic                mem_req;
  logic                mem_ack;
  logic [7:0]          mem_rdata;

  modport master (output mem_addr, output mem_req, input mem_ack, input mem_rdata);
  modport slave  (input mem_addr, input mem_req, output mem_ack, output mem_rdata);
endinterface

// File: rtl/instr_seq.sv
// Fetch/decode/execute/writeback sequencer for the 8-bit core; owns the PC.
// Optional HALT state on opcode 8'hFF is enabled with macro INSTR_SEQ_HALT_EN.
`ifndef OPCODE_ARITHMETIC_BIT
`define OPCODE_ARITHMETIC_BIT 3
`endif

module instr_seq #(
  parameter int                  PC_WIDTH   = 16,
  parameter logic [PC_WIDTH-1:0] RST_VECTOR = '0
) (
  input  logic                clk,
  input  logic                rst,
  instr_seq_if.master         mem,
  output logic [7:0]          instr,
  output logic                alu_en,
  output logic                we,
  input  logic                pc_load,
  input  logic [PC_WIDTH-1:0] pc_target,
  output logic [1:0]          state,
  output logic                halted
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [7:0]          instr_q, instr_d;
  logic                req, alu, wen, hlt;
  logic [1:0]          st;
  logic [3:0]          opc;

  assign opc = instr_q[7:4];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RST_VECTOR;
      instr_q <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    req     = 1'b0;
    alu     = 1'b0;
    wen     = 1'b0;
    hlt     = 1'b0;
    st      = state_q[1:0];
    case (state_q)
      S_FETCH: begin
        req = 1'b1;
        if (mem.mem_ack) begin
          instr_d = mem.mem_rdata;
          pc_d    = pc_q + 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
`ifdef INSTR_SEQ_HALT_EN
        if (instr_q == 8'hFF)                 state_d = S_HALT;
        else if (!opc[`OPCODE_ARITHMETIC_BIT]) state_d = S_EXEC;
        else                                   state_d = S_WB;
`else
        if (!opc[`OPCODE_ARITHMETIC_BIT]) state_d = S_EXEC;
        else                              state_d = S_WB;
`endif
      end
      S_EXEC: begin
        alu     = 1'b1;
        state_d = S_WB;
      end
      S_WB: begin
        wen     = 1'b1;
        if (pc_load) pc_d = pc_target;
        state_d = S_FETCH;
      end
      S_HALT: begin
        // Reports as WB on the 2-bit state bus; only halted distinguishes it.
        hlt = 1'b1;
        st  = 2'b11;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes are squashed while reset is asserted so nothing leaks in the reset cycle.
  assign mem.mem_req  = req & ~rst;
  assign mem.mem_addr = pc_q;
  assign alu_en       = alu & ~rst;
  assign we           = wen & ~rst;
  assign halted       = hlt & ~rst;
  assign instr        = instr_q;
  assign state        = st;

endmodule

// File: tb/tb_instr_seq.sv
// Bench for instr_seq: directed literal checks plus random traffic against a schedule model.
`ifndef OPCODE_ARITHMETIC_BIT
`define OPCODE_ARITHMETIC_BIT 3
`endif

module tb_instr_seq;
  localparam int PW = 16;
  localparam logic [PW-1:0] RSTV = 16'h0000;
`ifdef INSTR_SEQ_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    instr;
  logic          alu_en, we, pc_load, halted;
  logic [PW-1:0] pc_target;
  logic [1:0]    state;

  instr_seq_if #(.PC_WIDTH(PW)) bus ();

  instr_seq #(.PC_WIDTH(PW), .RST_VECTOR(RSTV)) dut (
    .clk(clk), .rst(rst), .mem(bus), .instr(instr), .alu_en(alu_en), .we(we),
    .pc_load(pc_load), .pc_target(pc_target), .state(state), .halted(halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Model: after an accepted fetch, the remaining cycles of the instruction are a fixed
  // schedule determined by the opcode class; an empty schedule means the core is fetching.
  typedef struct { logic [1:0] st; bit alu; bit w; bit hlt; } ent_t;
  ent_t          sched[$];
  logic [PW-1:0] m_pc;
  logic [7:0]    m_instr;
  bit            m_halt = 0;
  bit            armed  = 0;

  function automatic bit is_alu(input logic [7:0] b);
    logic [3:0] n;
    n = b[7:4];
    return n[`OPCODE_ARITHMETIC_BIT] == 1'b0;
  endfunction

  always @(posedge clk) begin
    ent_t e;
    if (rst) begin
      m_pc = RSTV; m_instr = 8'h00; sched.delete(); m_halt = 0; armed = 1;
    end else if (armed && !m_halt) begin
      if (sched.size() == 0) begin
        if (bus.mem_ack) begin
          m_instr = bus.mem_rdata;
          m_pc    = m_pc + 16'd1;
          if (HALT_EN && bus.mem_rdata == 8'hFF)
            sched.push_back('{2'd1, 1'b0, 1'b0, 1'b1});
          else begin
            sched.push_back('{2'd1, 1'b0, 1'b0, 1'b0});
            if (is_alu(bus.mem_rdata)) sched.push_back('{2'd2, 1'b1, 1'b0, 1'b0});
            sched.push_back('{2'd3, 1'b0, 1'b1, 1'b0});
          end
        end
      end else begin
        e = sched.pop_front();
        if (e.hlt) m_halt = 1;
        if (e.w && pc_load) m_pc = pc_target;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      bit fetching;
      logic [1:0] est;
      fetching = !m_halt && sched.size() == 0;
      est = m_halt ? 2'd3 : (fetching ? 2'd0 : sched[0].st);
      chk("state",    state,        est);
      chk("mem_addr", bus.mem_addr, m_pc);
      chk("instr",    instr,        m_instr);
      chk("mem_req",  bus.mem_req,  !rst && fetching);
      chk("alu_en",   alu_en,       !rst && !fetching && !m_halt && sched[0].alu);
      chk("we",       we,           !rst && !fetching && !m_halt && sched[0].w);
      chk("halted",   halted,       !rst && m_halt);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h12; pc_load = 1'b0; pc_target = '0;
    // 1: reset then an ALU instruction
    step(); step();
    rst = 1'b0; #1;
    chk("t1_req", bus.mem_req, 1); chk("t1_addr0", bus.mem_addr, 16'h0000);
    step(); bus.mem_ack = 1'b0;
    chk("t1_instr", instr, 8'h12); chk("t1_decode", state, 2'd1);
    step(); chk("t1_alu", alu_en, 1); chk("t1_we_lo", we, 0);
    step(); chk("t1_we", we, 1); chk("t1_alu_lo", alu_en, 0);
    step(); chk("t1_addr1", bus.mem_addr, 16'h0001); chk("t1_fetch", state, 2'd0);
    // reach PC=5 via a jump on a non-ALU instruction
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h80;
    step(); bus.mem_ack = 1'b0;
    step(); pc_load = 1'b1; pc_target = 16'h0005;
    step(); pc_load = 1'b0;
    // 2: idle ack cycles
    for (int i = 0; i < 3; i++) begin
      chk("t2_req", bus.mem_req, 1); chk("t2_addr", bus.mem_addr, 16'h0005);
      chk("t2_instr", instr, 8'h80); chk("t2_strb", {alu_en, we}, 2'b00);
      if (i < 2) step();
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h34;
    step(); bus.mem_ack = 1'b0;
    chk("t2_capture", instr, 8'h34);
    // 3: pc_load in EXEC ignored, honoured in WB
    step(); pc_load = 1'b1; pc_target = 16'h1234; chk("t3_exec", alu_en, 1);
    step(); chk("t3_wb_addr", bus.mem_addr, 16'h0006);
    step(); pc_load = 1'b0; chk("t3_jump", bus.mem_addr, 16'h1234);
    // 4: PC wrap on non-ALU instruction at 16'hFFFF
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h80;
    step(); bus.mem_ack = 1'b0;
    step(); pc_load = 1'b1; pc_target = 16'hFFFF;
    step(); pc_load = 1'b0; chk("t4_at_ffff", bus.mem_addr, 16'hFFFF);
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'hC3;
    step(); bus.mem_ack = 1'b0; chk("t4_decode", state, 2'd1);
    step(); chk("t4_we", we, 1); chk("t4_no_alu", alu_en, 0);
    step(); chk("t4_wrap", bus.mem_addr, 16'h0000);
    // 5: reset during an acked fetch
    rst = 1'b1; bus.mem_ack = 1'b1; bus.mem_rdata = 8'hA5; #1;
    chk("t5_req_lo", bus.mem_req, 0);
    step(); rst = 1'b0; bus.mem_ack = 1'b0;
    chk("t5_instr", instr, 8'h00); chk("t5_state", state, 2'd0); chk("t5_addr", bus.mem_addr, RSTV);
    // 6: opcode 8'hFF
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'hFF;
    step(); bus.mem_ack = 1'b0;
    step();
    if (HALT_EN) begin
      for (int i = 0; i < 12; i++) begin
        chk("t6_halted", halted, 1); chk("t6_req", bus.mem_req, 0); chk("t6_state", state, 2'd3);
        bus.mem_ack = i[0];
        step();
      end
      bus.mem_ack = 1'b0; rst = 1'b1; step(); rst = 1'b0;
      chk("t6_exit", {halted, state}, 3'b000);
    end else begin
      chk("t6_we", we, 1); chk("t6_halted", halted, 0);
      step(); chk("t6_next", bus.mem_addr, 16'h0001);
    end
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      rst           = ($urandom_range(0, 49) == 0);
      bus.mem_ack   = $urandom_range(0, 1);
      bus.mem_rdata = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
      pc_load       = ($urandom_range(0, 3) == 0);
      pc_target     = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      step();
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
